// File: rtl/sakebi_rmii_rx_pkg.sv
// Shared constants for the RMII receive path: preamble/SFD dibits and receive FSM states.
package sakebi_rmii_rx_pkg;

  localparam logic [1:0] DIBIT_PRE = 2'b01;
  localparam logic [1:0] DIBIT_SFD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_DISCARD,
    ST_EOF
  } rx_state_e;

endpackage

// File: rtl/sakebi_rmii_rx_if.sv
// AXI-Stream byte interface of the RMII receiver; SAKEBI_RMII_RX_TUSER_EN adds the tuser error flag.
interface sakebi_rmii_rx_if #(
  parameter int DW = 8
);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;
`ifdef SAKEBI_RMII_RX_TUSER_EN
  logic          tuser;

  modport master (output tvalid, tdata, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, tuser, output tready);
`else
  modport master (output tvalid, tdata, tlast, input tready);
  modport slave  (input tvalid, tdata, tlast, output tready);
`endif
endinterface

// File: rtl/sakebi_async_fifo.sv
// Dual-clock FIFO with gray-coded pointers and 2-FF pointer synchronisers in each direction.
module sakebi_async_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10
) (
  input  logic             wr_clk,
  input  logic             wr_rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_clk,
  input  logic             rd_rst_n,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_bin_q, wr_bin_d, wr_gray_q, wr_gray_d;
  logic [AW:0] rd_bin_q, rd_bin_d, rd_gray_q, rd_gray_d;
  logic [AW:0] rd_gray_s1_q, rd_gray_s2_q, wr_gray_s1_q, wr_gray_s2_q;
  logic [AW:0] rd_bin_w, used_w;
  logic        wr_fire, rd_fire;

  for (genvar gi = 0; gi <= AW; gi++) begin : g_gray2bin
    assign rd_bin_w[gi] = ^rd_gray_s2_q[AW:gi];
  end

  // One slot is held back so that this FIFO plus the reader's output register
  // buffer exactly DEPTH entries in total.
  assign used_w   = wr_bin_q - rd_bin_w;
  assign wr_ready = (used_w < (AW+1)'(DEPTH - 1));
  assign wr_fire  = wr_en && wr_ready;
  assign rd_valid = (rd_gray_q != wr_gray_s2_q);
  assign rd_fire  = rd_en && rd_valid;
  assign rd_data  = mem[rd_bin_q[AW-1:0]];

  always_comb begin
    wr_bin_d  = wr_bin_q + {{AW{1'b0}}, wr_fire};
    wr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);
    rd_bin_d  = rd_bin_q + {{AW{1'b0}}, rd_fire};
    rd_gray_d = rd_bin_d ^ (rd_bin_d >> 1);
  end

  always_ff @(posedge wr_clk) begin
    if (wr_fire) mem[wr_bin_q[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_bin_q     <= '0;
      wr_gray_q    <= '0;
      rd_gray_s1_q <= '0;
      rd_gray_s2_q <= '0;
    end else begin
      wr_bin_q     <= wr_bin_d;
      wr_gray_q    <= wr_gray_d;
      rd_gray_s1_q <= rd_gray_q;
      rd_gray_s2_q <= rd_gray_s1_q;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_bin_q     <= '0;
      rd_gray_q    <= '0;
      wr_gray_s1_q <= '0;
      wr_gray_s2_q <= '0;
    end else begin
      rd_bin_q     <= rd_bin_d;
      rd_gray_q    <= rd_gray_d;
      wr_gray_s1_q <= wr_gray_q;
      wr_gray_s2_q <= wr_gray_s1_q;
    end
  end
endmodule

// File: rtl/sakebi_rst_sync.sv
// Reset synchroniser: asserts asynchronously, releases two clk edges after arst_n rises.
module sakebi_rst_sync (
  input  logic clk,
  input  logic arst_n,
  output logic rst_n
);
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) sync_q <= '0;
    else         sync_q <= {sync_q[0], 1'b1};
  end

  assign rst_n = sync_q[1];
endmodule

// File: rtl/sakebi_rmii_rx.sv
// RMII (REF_CLK) receive path to AXI-Stream on i_axis_ACLK; FCS passed through unchecked.
// Optional macro SAKEBI_RMII_RX_TUSER_EN exposes the frame error bit as tuser. DATA_WIDTH must be 8.
module sakebi_rmii_rx
  import sakebi_rmii_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int MIN_PRE    = 4
) (
  input  logic                   i_axis_ACLK,
  input  logic                   i_axis_ARESETn,
  input  logic                   i_rmii_REF_CLK,
  input  logic                   i_rmii_CRS_DV,
  input  logic [1:0]             i_rmii_RXD,
  sakebi_rmii_rx_if.master       axis
);
  localparam int EW = DATA_WIDTH + 2;

  logic                  ref_rst_n;
  logic                  crs_q;
  logic [1:0]            rxd_q;
  rx_state_e             state_q, state_d;
  logic [7:0]            pre_cnt_q, pre_cnt_d;
  logic [1:0]            dib_cnt_q, dib_cnt_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d, hold_q, hold_d, byte_w;
  logic                  hold_vld_q, hold_vld_d, pend_eof_q, pend_eof_d;
  logic                  wr_en, wr_ready;
  logic [EW-1:0]         wr_data, fifo_rd_data;
  logic                  fifo_rd_valid, load_w;
  logic                  out_vld_q, out_vld_d, out_last_q, out_last_d, out_err_q, out_err_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  sakebi_rst_sync u_rst_sync (
    .clk    (i_rmii_REF_CLK),
    .arst_n (i_axis_ARESETn),
    .rst_n  (ref_rst_n)
  );

  always_ff @(posedge i_rmii_REF_CLK or negedge ref_rst_n) begin
    if (!ref_rst_n) begin
      crs_q      <= 1'b0;
      rxd_q      <= 2'b00;
      state_q    <= ST_IDLE;
      pre_cnt_q  <= '0;
      dib_cnt_q  <= '0;
      sr_q       <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      pend_eof_q <= 1'b0;
    end else begin
      crs_q      <= i_rmii_CRS_DV;
      rxd_q      <= i_rmii_RXD;
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      dib_cnt_q  <= dib_cnt_d;
      sr_q       <= sr_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      pend_eof_q <= pend_eof_d;
    end
  end

  assign byte_w = {rxd_q, sr_q[DATA_WIDTH-1:2]};

  // Bytes are delayed by one in the hold register so the final byte can be
  // tagged with last/err once carrier loss is seen.
  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    dib_cnt_d  = dib_cnt_q;
    sr_d       = sr_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    pend_eof_d = pend_eof_q;
    wr_en      = 1'b0;
    wr_data    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (crs_q) begin
          state_d   = ST_PRE;
          pre_cnt_d = '0;
        end
      end
      ST_PRE: begin
        if (crs_q && rxd_q == DIBIT_PRE) begin
          if (pre_cnt_q != 8'hFF) pre_cnt_d = pre_cnt_q + 8'd1;
        end else if (crs_q && rxd_q == DIBIT_SFD && int'(pre_cnt_q) >= MIN_PRE) begin
          state_d    = ST_DATA;
          dib_cnt_d  = '0;
          hold_vld_d = 1'b0;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      ST_DATA: begin
        if (crs_q) begin
          sr_d      = byte_w;
          dib_cnt_d = dib_cnt_q + 2'd1;
          if (dib_cnt_q == 2'd3) begin
            hold_d     = byte_w;
            hold_vld_d = 1'b1;
            if (hold_vld_q) begin
              wr_data = {1'b0, 1'b0, hold_q};
              if (wr_ready) begin
                wr_en = 1'b1;
              end else begin
                state_d    = ST_DISCARD;
                pend_eof_d = 1'b1;
              end
            end
          end
        end else begin
          state_d = ST_IDLE;
          if (hold_vld_q) begin
            wr_data = {dib_cnt_q != 2'd0, 1'b1, hold_q};
            if (wr_ready) begin
              wr_en = 1'b1;
            end else begin
              state_d    = ST_DISCARD;
              pend_eof_d = 1'b1;
            end
          end
        end
      end
      ST_DISCARD: begin
        if (!crs_q) state_d = pend_eof_q ? ST_EOF : ST_IDLE;
      end
      ST_EOF: begin
        wr_data = {1'b1, 1'b1, {DATA_WIDTH{1'b0}}};
        if (wr_ready) begin
          wr_en      = 1'b1;
          pend_eof_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  sakebi_async_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .wr_clk   (i_rmii_REF_CLK),
    .wr_rst_n (ref_rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_clk   (i_axis_ACLK),
    .rd_rst_n (i_axis_ARESETn),
    .rd_en    (load_w),
    .rd_data  (fifo_rd_data),
    .rd_valid (fifo_rd_valid)
  );

  assign load_w = fifo_rd_valid && (!out_vld_q || axis.tready);

  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    out_err_d  = out_err_q;
    if (load_w) begin
      out_vld_d = 1'b1;
      {out_err_d, out_last_d, out_data_d} = fifo_rd_data;
    end else if (axis.tready) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_err_q  <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_err_q  <= out_err_d;
    end
  end

  assign axis.tvalid = out_vld_q;
  assign axis.tdata  = out_data_q;
  assign axis.tlast  = out_last_q;
`ifdef SAKEBI_RMII_RX_TUSER_EN
  assign axis.tuser  = out_err_q;
`else
  // Without tuser the error flag is dropped; error frames still close with tlast.
  logic err_unused;
  assign err_unused = out_err_q;
`endif
endmodule

// File: tb/tb_sakebi_rmii_rx.sv
// Directed bench for sakebi_rmii_rx: RMII dibit stimulus, AXIS beat capture, hand-computed expectations.
module tb_sakebi_rmii_rx;
  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  logic       aclk = 1'b0;
  logic       ref_clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       crs = 1'b0;
  logic [1:0] rxd = 2'b00;
  int         n_chk = 0;
  int         n_err = 0;
  beat_t      beats[$];
  logic [7:0] tx_q[$];
  logic [8:0] exp_q[$];

  sakebi_rmii_rx_if #(.DW(8)) axis ();

  sakebi_rmii_rx #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (16),
    .MIN_PRE    (4)
  ) dut (
    .i_axis_ACLK    (aclk),
    .i_axis_ARESETn (arst_n),
    .i_rmii_REF_CLK (ref_clk),
    .i_rmii_CRS_DV  (crs),
    .i_rmii_RXD     (rxd),
    .axis           (axis)
  );

  always #4  aclk = ~aclk;
  always #10 ref_clk = ~ref_clk;

  // Capture on the falling edge: values here are what the next rising edge transfers.
  always @(negedge aclk) begin
    if (axis.tvalid && axis.tready) begin
`ifdef SAKEBI_RMII_RX_TUSER_EN
      beats.push_back('{d: axis.tdata, l: axis.tlast, u: axis.tuser});
`else
      beats.push_back('{d: axis.tdata, l: axis.tlast, u: 1'b0});
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("pass %s: got=%0h", tag, got);
    end
  endtask

  task automatic dib(input logic c, input logic [1:0] d);
    @(negedge ref_clk);
    crs = c;
    rxd = d;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) dib(1'b1, b[2*k +: 2]);
  endtask

  task automatic send_pre(input int n);
    for (int k = 0; k < n; k++) dib(1'b1, 2'b01);
    dib(1'b1, 2'b11);
  endtask

  task automatic gap();
    for (int k = 0; k < 8; k++) dib(1'b0, 2'b00);
  endtask

  task automatic send_frame(input int npre);
    send_pre(npre);
    foreach (tx_q[k]) send_byte(tx_q[k]);
    gap();
  endtask

  task automatic exp_from_tx();
    exp_q.delete();
    foreach (tx_q[k]) exp_q.push_back({tx_q[k], k == tx_q.size() - 1});
  endtask

  task automatic set_ready(input logic r);
    @(posedge aclk);
    #1 axis.tready = r;
  endtask

  task automatic wait_beats(input int n);
    int cyc = 0;
    while (beats.size() < n && cyc < 1000) begin
      @(posedge aclk);
      cyc++;
    end
    repeat (40) @(posedge aclk);
  endtask

  task automatic check_frame(input string tag, input logic exp_err);
    wait_beats(exp_q.size());
    chk({tag, "_count"}, beats.size(), exp_q.size());
    for (int i = 0; i < beats.size() && i < exp_q.size(); i++)
      chk({tag, "_beat"}, {beats[i].d, beats[i].l}, exp_q[i]);
`ifdef SAKEBI_RMII_RX_TUSER_EN
    if (beats.size() > 0) chk({tag, "_tuser"}, beats[beats.size()-1].u, exp_err);
`else
    if (exp_err) $display("note %s: error frame, no tuser in this build", tag);
`endif
    beats.delete();
    exp_q.delete();
  endtask

  task automatic check_none(input string tag);
    repeat (100) @(posedge aclk);
    chk({tag, "_no_beats"}, beats.size(), 0);
    beats.delete();
  endtask

  task automatic stall_window();
    int         c = 0;
    logic       have = 1'b0;
    logic [8:0] held = '0;
    while (beats.size() < 5 && c < 3000) begin
      @(posedge aclk);
      c++;
    end
    #1 axis.tready = 1'b0;
    repeat (20) begin
      @(negedge aclk);
      if (axis.tvalid) begin
        if (!have) begin
          held = {axis.tdata, axis.tlast};
          have = 1'b1;
        end else begin
          chk("t2_stable", {axis.tdata, axis.tlast}, held);
        end
      end
    end
    chk("t2_stall_saw_valid", have, 1'b1);
    set_ready(1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    axis.tready = 1'b1;
    #1;
    chk("rst_tvalid", axis.tvalid, 1'b0);
    chk("rst_tdata", axis.tdata, 8'h00);
    chk("rst_tlast", axis.tlast, 1'b0);
    repeat (5) @(posedge aclk);
    #1 arst_n = 1'b1;
    repeat (10) @(negedge ref_clk);

    // 1: standard preamble 7x55 + D5 (31 dibits 01 then 11), three bytes
    tx_q = '{8'h01, 8'h02, 8'h03};
    exp_from_tx();
    send_frame(31);
    check_frame("t1", 1'b0);

    // 2: 60-byte frame with a 20-cycle stall in the middle
    tx_q.delete();
    for (int k = 0; k < 60; k++) tx_q.push_back(8'(k * 5 + 3));
    exp_from_tx();
    fork
      send_frame(31);
      stall_window();
    join
    check_frame("t2", 1'b0);

    // 3: carrier lost two dibits into the fourth byte
    exp_q = '{{8'hAA, 1'b0}, {8'hBB, 1'b0}, {8'hCC, 1'b1}};
    send_pre(31);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    dib(1'b1, 2'b01);
    dib(1'b1, 2'b11);
    gap();
    check_frame("t3", 1'b1);

    // 4: overflow while stalled: 16 bytes survive, then an error terminator
    set_ready(1'b0);
    tx_q.delete();
    for (int k = 0; k < 40; k++) tx_q.push_back(8'(k * 7 + 1));
    send_frame(31);
    repeat (50) @(posedge aclk);
    chk("t4_hold_valid", axis.tvalid, 1'b1);
    chk("t4_hold_data", axis.tdata, 8'h01);
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back({8'(k * 7 + 1), 1'b0});
    exp_q.push_back({8'h00, 1'b1});
    set_ready(1'b1);
    check_frame("t4", 1'b1);
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_from_tx();
    send_frame(31);
    check_frame("t4_next", 1'b0);

    // 5: bad preambles produce nothing; the MIN_PRE boundary is accepted
    tx_q = '{8'h11, 8'h22, 8'h33};
    send_frame(2);
    check_none("t5_short");
    dib(1'b1, 2'b01);
    dib(1'b1, 2'b01);
    dib(1'b1, 2'b10);
    foreach (tx_q[k]) send_byte(tx_q[k]);
    gap();
    check_none("t5_bad_dibit");
    send_frame(3);
    check_none("t5_three");
    tx_q = '{8'h5A, 8'hA5};
    exp_from_tx();
    send_frame(5);
    check_frame("t5_min_pre", 1'b0);

    // 6: reset pulsed mid-frame
    send_pre(31);
    send_byte(8'h10);
    dib(1'b1, 2'b00);
    arst_n = 1'b0;
    #1;
    chk("t6_rst_tvalid", axis.tvalid, 1'b0);
    chk("t6_rst_tdata", axis.tdata, 8'h00);
    chk("t6_rst_tlast", axis.tlast, 1'b0);
    repeat (3) dib(1'b1, 2'b00);
    arst_n = 1'b1;
    for (int k = 0; k < 4; k++) send_byte(8'h00);
    gap();
    check_none("t6_dropped");
    tx_q = '{8'hC3, 8'h3C, 8'h99};
    exp_from_tx();
    send_frame(31);
    check_frame("t6_next", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
